// File: rtl/demo_uart_pkg.sv
// Shared types and constants for the demo UART transmitter.
package demo_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/demo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
module demo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_inner,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_inner or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_inner) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/demo_uart_tx.sv
// UART 8N1 transmitter fed from a small FIFO, gated by the clock-wizard lock.
module demo_uart_tx
  import demo_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_inner,
  input  logic       reset,
  input  logic       locked,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : gen_baud_check
    $error("CLKS_PER_BIT must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e      state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       push, pop, bit_done, frame_end;

  assign in_ready  = locked && !fifo_full;
  assign push      = in_valid && in_ready;
  assign bit_done  = (baud_cnt_q == LAST_CNT);
  assign frame_end = (state_q == StStop) && bit_done && (bit_idx_q == LAST_STOP);
  // A new frame starts from idle or straight out of the last stop bit.
  assign pop       = !fifo_empty && locked && ((state_q == StIdle) || frame_end);

  assign txd  = txd_q;
  assign busy = (state_q != StIdle) || !fifo_empty;

  demo_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_inner(clk_inner),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (in_data),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_inner or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q    <= StStart;
            shift_q    <= fifo_rdata;
            txd_q      <= 1'b0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q    <= StData;
            baud_cnt_q <= '0;
            txd_q      <= shift_q[0];
            shift_q    <= shift_q >> 1;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == LAST_DATA) begin
              state_q   <= StStop;
              bit_idx_q <= '0;
              txd_q     <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        StStop: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == LAST_STOP) begin
              bit_idx_q <= '0;
              if (pop) begin
                state_q <= StStart;
                shift_q <= fifo_rdata;
                txd_q   <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demo_uart_tx.sv
// Self-checking bench for demo_uart_tx: directed tables plus randomized traffic vs a frame-level model.
module tb_demo_uart_tx;
  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned BAUD   = 100;
  localparam int          DEPTH  = 4;
  localparam int          CPB    = CLK_HZ / BAUD;
  localparam int          FRAME  = 10 * CPB;

  logic       clk_inner = 1'b0;
  logic       reset, locked, in_valid;
  logic [7:0] in_data;
  logic       in_ready, txd, busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_inner = ~clk_inner;

  demo_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_inner(clk_inner),
    .reset    (reset),
    .locked   (locked),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .txd      (txd),
    .busy     (busy)
  );

  // Frame-level reference: a byte queue plus the time since the current frame started.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_in_frame;
  int         m_pos;
  bit         m_pushed;

  task automatic model_clear();
    m_q.delete();
    m_in_frame = 0;
    m_pos      = 0;
    m_pushed   = 0;
  endtask

  task automatic model_edge();
    bit push, done;
    push = (in_valid === 1'b1) && (locked === 1'b1) && (m_q.size() < DEPTH);
    done = m_in_frame && (m_pos == FRAME - 1);
    m_pushed = push;
    if ((!m_in_frame || done) && m_q.size() > 0 && locked === 1'b1) begin
      m_cur      = m_q.pop_front();
      m_in_frame = 1;
      m_pos      = 0;
    end else if (done) begin
      m_in_frame = 0;
    end else if (m_in_frame) begin
      m_pos++;
    end
    if (push) m_q.push_back(in_data);
  endtask

  function automatic logic m_txd();
    int b;
    if (!m_in_frame) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic m_ready();
    return (locked === 1'b1) && (m_q.size() < DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, check in_ready, clock once, check outputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic lk);
    in_valid = v;
    in_data  = d;
    locked   = lk;
    #1;
    check("in_ready", in_ready, m_ready());
    @(posedge clk_inner);
    if (reset) model_clear();
    else model_edge();
    @(negedge clk_inner);
    check("txd", txd, m_txd());
    check("busy", busy, m_in_frame || (m_q.size() > 0));
  endtask

  // Independent line receiver: samples each bit in its middle.
  task automatic capture_frame(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (txd !== 1'b0 && n < 3000) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("rx_start", txd, 1'b0);
    repeat (CPB + CPB / 2) cycle(1'b0, 8'h00, 1'b1);
    b[0] = txd;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB) cycle(1'b0, 8'h00, 1'b1);
      b[i] = txd;
    end
    repeat (CPB) cycle(1'b0, 8'h00, 1'b1);
    check("rx_stop", txd, 1'b1);
    repeat (CPB / 2 - 1) cycle(1'b0, 8'h00, 1'b1);
  endtask

  typedef struct {
    int   cyc;
    logic txd;
    logic busy;
  } vec_t;

  vec_t       tab[15];
  logic [7:0] rx;
  int         idx, nxt, acc_idx, n;
  logic       lk;

  initial begin
    // 0xA5 sent from idle; cyc counts rising edges after the push edge.
    tab[0]  = '{0, 1'b1, 1'b1};   tab[1]  = '{1, 1'b0, 1'b1};
    tab[2]  = '{10, 1'b0, 1'b1};  tab[3]  = '{11, 1'b1, 1'b1};
    tab[4]  = '{20, 1'b1, 1'b1};  tab[5]  = '{21, 1'b0, 1'b1};
    tab[6]  = '{31, 1'b1, 1'b1};  tab[7]  = '{41, 1'b0, 1'b1};
    tab[8]  = '{51, 1'b0, 1'b1};  tab[9]  = '{61, 1'b1, 1'b1};
    tab[10] = '{71, 1'b0, 1'b1};  tab[11] = '{81, 1'b1, 1'b1};
    tab[12] = '{91, 1'b1, 1'b1};  tab[13] = '{100, 1'b1, 1'b1};
    tab[14] = '{101, 1'b1, 1'b0};

    model_clear();
    reset    = 1'b0;
    locked   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2 reset = 1'b1;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready_unlocked", in_ready, 1'b0);
    locked = 1'b1;
    #1 check("rst_ready_locked", in_ready, 1'b1);
    @(negedge clk_inner);
    reset = 1'b0;

    // Single byte from idle.
    cycle(1'b1, 8'hA5, 1'b1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      while (n < tab[i].cyc) begin
        cycle(1'b0, 8'h00, 1'b1);
        n++;
      end
      check($sformatf("a5_txd@%0d", tab[i].cyc), txd, tab[i].txd);
      check($sformatf("a5_busy@%0d", tab[i].cyc), busy, tab[i].busy);
    end

    // Burst 0x00..0x05 with in_valid held until each is taken.
    nxt = 0; idx = 0; acc_idx = -1;
    while (nxt < 6 && idx < 400) begin
      cycle(1'b1, 8'(nxt), 1'b1);
      if (m_pushed) begin
        if (nxt == 5) acc_idx = idx;
        nxt++;
      end
      idx++;
    end
    check("burst_accept5_edge", acc_idx, 102);
    while (busy === 1'b1 && idx < 900) begin
      cycle(1'b0, 8'h00, 1'b1);
      idx++;
    end
    check("burst_idle_edge", idx - 1, 1 + 6 * FRAME);

    // Lock drops mid-frame with two bytes queued.
    cycle(1'b1, 8'h11, 1'b1);
    cycle(1'b1, 8'h22, 1'b1);
    cycle(1'b1, 8'h33, 1'b1);
    for (int p = 2; p < 150; p++) cycle(1'b0, 8'h00, (p < 30) ? 1'b1 : 1'b0);
    check("unlock_txd_idle", txd, 1'b1);
    check("unlock_busy", busy, 1'b1);
    check("unlock_ready", in_ready, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("relock_start", txd, 1'b0);
    capture_frame(rx);
    check("relock_byte0", rx, 8'h22);
    capture_frame(rx);
    check("relock_byte1", rx, 8'h33);
    cycle(1'b0, 8'h00, 1'b1);
    check("relock_done_busy", busy, 1'b0);

    // Push on the same edge that pops for the next frame.
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h02, 1'b1);
    for (int p = 1; p < FRAME; p++) cycle(1'b0, 8'h00, 1'b1);
    check("pp_ready", in_ready, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    check("pp_start", txd, 1'b0);
    check("pp_busy", busy, 1'b1);
    capture_frame(rx);
    check("pp_byte0", rx, 8'h02);
    capture_frame(rx);
    check("pp_byte1", rx, 8'h3C);
    cycle(1'b0, 8'h00, 1'b1);
    check("pp_empty_after", busy, 1'b0);

    // Reset during data bit 3 with one byte queued.
    cycle(1'b1, 8'h5A, 1'b1);
    cycle(1'b1, 8'h77, 1'b1);
    for (int p = 1; p <= 4 * CPB + CPB / 2; p++) cycle(1'b0, 8'h00, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    model_clear();
    @(negedge clk_inner);
    reset = 1'b0;
    for (int p = 0; p < 200; p++) cycle(1'b0, 8'h00, 1'b1);
    check("postrst_txd", txd, 1'b1);
    check("postrst_busy", busy, 1'b0);

    // Randomized traffic with occasional lock loss.
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) lk = ~lk;
      cycle(($urandom_range(0, 99) < ((i < 2000) ? 2 : 30)) ? 1'b1 : 1'b0,
            8'($urandom), lk);
    end
    n = 0;
    while ((m_in_frame || m_q.size() > 0) && n < 2000) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("rand_drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
